// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bridge types and widths.
//   apb_state_t : bridge FSM states IDLE/SETUP/ACCESS
//   apb_rsp_t   : response bundle {rdata, slverr, timeout}
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts stalled ACCESS cycles and flags the aborting edge.
//   PCLK, PRESETn : clock, async active-low reset
//   i_clear       : zero the count (held while the transfer is in SETUP)
//   i_enable      : count this cycle (ACCESS with PREADY low)
//   o_expired     : this edge brings the count to TIMEOUT_CYCLES
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = i_enable & (r_cnt == W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_cnt <= '0;
    else r_cnt <= i_clear ? '0 : i_enable ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to APB initiator (SETUP -> ACCESS).
//   PCLK, PRESETn                  : clock, async active-low reset
//   req_valid/ready/write/addr/wdata : single-command request port
//   rsp_valid/rdata/slverr/timeout : one-cycle completion strobe with held status
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR : APB master side
//   Optional ACCESS timeout abort: define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge import apb_pkg::*; #(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  apb_state_t r_state;
  logic       w_accept;
  logic       w_abort;
  assign req_ready = (r_state == IDLE) | ((r_state == ACCESS) & PREADY);
  assign w_accept  = req_valid & req_ready;
`ifdef APB_MASTER_TIMEOUT_EN
  logic r_timeout;
  apb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_clear   (r_state == SETUP),
    .i_enable  ((r_state == ACCESS) & ~PREADY),
    .o_expired (w_abort)
  );
  assign rsp_timeout = r_timeout;
`else
  assign w_abort     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_state    <= IDLE;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      // Capture happens in IDLE or on a completion edge; ACCESS otherwise holds PADDR/PWDATA.
      if (w_accept) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
      case (r_state)
        IDLE:
          if (req_valid) begin
            PSELx   <= 1'b1;
            r_state <= SETUP;
          end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS:
          if (PREADY) begin
            rsp_valid  <= 1'b1;
            rsp_slverr <= PSLVERR;
            rsp_rdata  <= PWRITE ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
            PENABLE    <= 1'b0;
            // Back-to-back: keep PSELx high so the next SETUP follows with no IDLE gap.
            PSELx      <= req_valid;
            r_state    <= req_valid ? SETUP : IDLE;
          end else if (w_abort) begin
            rsp_valid  <= 1'b1;
            rsp_slverr <= 1'b1;
            rsp_rdata  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_timeout  <= 1'b1;
`endif
            PENABLE    <= 1'b0;
            PSELx      <= 1'b0;
            r_state    <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule
